// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-programmable pattern of 1..MAX_LEN bits.
// Optional saturating match counter is built when SEQDET_MATCH_CNT_EN is defined.
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0]   LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   LEN_RST = LEN_W'(3);
  localparam logic [MAX_LEN-1:0] PAT_RST = MAX_LEN'(3'b110);

  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  // The oldest bit falls off on every shift and is never compared, so only
  // MAX_LEN-1 bits of history need to be stored.
  logic [MAX_LEN-2:0] hist_q;
  logic [LEN_W-1:0]   fill_q;

  logic [MAX_LEN-1:0] hist_shift;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_inc;
  logic [LEN_W-1:0]   len_clamped;
  logic               match;

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    len_clamped = cfg_len;
    if (cfg_len == '0) begin
      len_clamped = LEN_W'(1);
    end else if (cfg_len > LEN_MAX) begin
      len_clamped = LEN_MAX;
    end

    hist_shift = {hist_q, in_bit};
    fill_inc   = (fill_q == LEN_MAX) ? fill_q : fill_q + LEN_W'(1);

    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end

    // Only the low len bits take part; pattern bits above len are don't-care.
    match = in_valid && (fill_inc >= len_q) &&
            ((hist_shift & mask) == (pat_q & mask));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q     <= PAT_RST;
      len_q     <= LEN_RST;
      overlap_q <= 1'b1;
      hist_q    <= '0;
      fill_q    <= '0;
      detected  <= 1'b0;
    end else if (cfg_load) begin
      pat_q     <= cfg_pattern;
      len_q     <= len_clamped;
      overlap_q <= cfg_overlap;
      hist_q    <= '0;
      fill_q    <= '0;
      detected  <= 1'b0;
    end else begin
      detected <= match;
      if (in_valid) begin
        hist_q <= hist_shift[MAX_LEN-2:0];
        // Non-overlapping mode restarts filling so the next match needs len fresh bits.
        fill_q <= (match && !overlap_q) ? '0 : fill_inc;
      end
    end
  end

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || cfg_load) begin
      cnt_q <= '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign match_count = cnt_q;
`else
  assign match_count = '0;
`endif

endmodule
